fpu_add_sub_arbiter: RTL

// Shares the single combinational FP32 add/sub datapath between two requesters (req0: FADD/FSUB

---
 rtl/fpu_add_sub_arbiter_if.sv | 69 ++++++
 rtl/fpu_add_sub_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/fpu_add_sub_arbiter_if.sv
// Request, datapath and response signals of the shared FP32 add/sub arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic's view.
interface fpu_add_sub_arbiter_if #(
  parameter int unsigned TAG_W = 5
);
  logic             req0_valid_i;
  logic             req0_ready_o;
  logic [31:0]      req0_a_i;
  logic [31:0]      req0_b_i;
  logic             req0_sub_i;
  logic [2:0]       req0_rm_i;
  logic [TAG_W-1:0] req0_tag_i;

  logic             req1_valid_i;
  logic             req1_ready_o;
  logic [31:0]      req1_a_i;
  logic [31:0]      req1_b_i;
  logic             req1_sub_i;
  logic [2:0]       req1_rm_i;
  logic [TAG_W-1:0] req1_tag_i;

  logic [2:0]       frm_i;
  logic             flush_i;

  logic [31:0]      dp_a_o;
  logic [31:0]      dp_b_o;
  logic             dp_sub_o;
  logic [2:0]       dp_rm_o;
  logic [31:0]      dp_res_i;
  logic [4:0]       dp_flags_i;

  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [31:0]      rsp_res_o;
  logic [4:0]       rsp_flags_o;
  logic [TAG_W-1:0] rsp_tag_o;
  logic             rsp_src_o;

  logic             fflags_clr_i;
  logic [4:0]       fflags_o;

  modport slave (
    input  req0_valid_i, req0_a_i, req0_b_i, req0_sub_i, req0_rm_i, req0_tag_i,
    output req0_ready_o,
    input  req1_valid_i, req1_a_i, req1_b_i, req1_sub_i, req1_rm_i, req1_tag_i,
    output req1_ready_o,
    input  frm_i, flush_i,
    output dp_a_o, dp_b_o, dp_sub_o, dp_rm_o,
    input  dp_res_i, dp_flags_i,
    output rsp_valid_o, rsp_res_o, rsp_flags_o, rsp_tag_o, rsp_src_o,
    input  rsp_ready_i,
    input  fflags_clr_i,
    output fflags_o
  );

  modport master (
    output req0_valid_i, req0_a_i, req0_b_i, req0_sub_i, req0_rm_i, req0_tag_i,
    input  req0_ready_o,
    output req1_valid_i, req1_a_i, req1_b_i, req1_sub_i, req1_rm_i, req1_tag_i,
    input  req1_ready_o,
    output frm_i, flush_i,
    input  dp_a_o, dp_b_o, dp_sub_o, dp_rm_o,
    output dp_res_i, dp_flags_i,
    input  rsp_valid_o, rsp_res_o, rsp_flags_o, rsp_tag_o, rsp_src_o,
    output rsp_ready_i,
    output fflags_clr_i,
    input  fflags_o
  );
endinterface

// File: rtl/fpu_add_sub_arbiter.sv
// Round-robin share of one combinational FP32 add/sub datapath between two requesters,
// with registered operands/result, dynamic rounding resolution and sticky fflags.
module fpu_add_sub_arbiter #(
  parameter int unsigned TAG_W   = 5,
  parameter bit          RR_INIT = 1'b0
) (
  input logic                 clk_i,
  input logic                 reset_i,
  fpu_add_sub_arbiter_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic             sub_q, sub_d;
  logic [2:0]       rm_q, rm_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             src_q, src_d;
  logic [31:0]      res_q, res_d;
  logic [4:0]       flags_q, flags_d;
  logic [4:0]       fflags_q, fflags_d;

  logic       grant0, grant1, hs, window;
  logic [2:0] rm_sel;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    rm_d     = rm_q;
    tag_d    = tag_q;
    src_d    = src_q;
    res_d    = res_q;
    flags_d  = flags_q;
    fflags_d = fflags_q;
    grant0   = 1'b0;
    grant1   = 1'b0;
    rm_sel   = '0;

    // Flush drops a pending response, so it also suppresses the handshake.
    hs     = (state_q == ST_DONE) && bus.rsp_ready_i && !bus.flush_i;
    window = !reset_i && !bus.flush_i && ((state_q == ST_IDLE) || hs);

    if (window) begin
      if (bus.req0_valid_i && bus.req1_valid_i) begin
        grant0 = last_q;
        grant1 = !last_q;
      end else begin
        grant0 = bus.req0_valid_i;
        grant1 = bus.req1_valid_i;
      end
    end

    if (grant0 || grant1) begin
      last_d = grant1;
      src_d  = grant1;
      a_d    = grant1 ? bus.req1_a_i   : bus.req0_a_i;
      b_d    = grant1 ? bus.req1_b_i   : bus.req0_b_i;
      sub_d  = grant1 ? bus.req1_sub_i : bus.req0_sub_i;
      tag_d  = grant1 ? bus.req1_tag_i : bus.req0_tag_i;
      rm_sel = grant1 ? bus.req1_rm_i  : bus.req0_rm_i;
      rm_d   = (rm_sel == 3'b111) ? bus.frm_i : rm_sel;
    end

    if ((state_q == ST_EXEC) && !bus.flush_i) begin
      if ((rm_q == 3'b101) || (rm_q == 3'b110)) begin
        res_d   = 32'h7fc0_0000;
        flags_d = 5'b10000;
      end else begin
        res_d   = bus.dp_res_i;
        flags_d = bus.dp_flags_i;
      end
    end

    if (hs) begin
      fflags_d = (bus.fflags_clr_i ? 5'b00000 : fflags_q) | flags_q;
    end else if (bus.fflags_clr_i) begin
      fflags_d = '0;
    end

    case (state_q)
      ST_IDLE: if (grant0 || grant1) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: if (hs) state_d = (grant0 || grant1) ? ST_EXEC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.flush_i) state_d = ST_IDLE;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      last_q   <= ~RR_INIT;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      rm_q     <= '0;
      tag_q    <= '0;
      src_q    <= 1'b0;
      res_q    <= '0;
      flags_q  <= '0;
      fflags_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      rm_q     <= rm_d;
      tag_q    <= tag_d;
      src_q    <= src_d;
      res_q    <= res_d;
      flags_q  <= flags_d;
      fflags_q <= fflags_d;
    end
  end

  assign bus.req0_ready_o = grant0;
  assign bus.req1_ready_o = grant1;
  assign bus.dp_a_o       = a_q;
  assign bus.dp_b_o       = b_q;
  assign bus.dp_sub_o     = sub_q;
  assign bus.dp_rm_o      = rm_q;
  assign bus.rsp_valid_o  = (state_q == ST_DONE);
  assign bus.rsp_res_o    = res_q;
  assign bus.rsp_flags_o  = flags_q;
  assign bus.rsp_tag_o    = tag_q;
  assign bus.rsp_src_o    = src_q;
  assign bus.fflags_o     = fflags_q;

endmodule
